// File: rtl/iobus_timer_pkg.sv
// Shared constants and types for the memory-mapped interval timer.
package iobus_timer_pkg;

  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_PERIOD = 4'h4;
  localparam logic [3:0] OFS_COUNT  = 4'h8;
  localparam logic [3:0] OFS_STATUS = 4'hC;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_IE   = 2;

  typedef enum logic {IDLE, RUN} timer_state_t;

endpackage

// File: rtl/iobus_prescaler.sv
// Tick generator: one-cycle pulse every PRESCALE enabled cycles, restartable via clr.
module iobus_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/iobus_timer.sv
// Interval timer on the OTTER I/O bus: CTRL/PERIOD/COUNT/STATUS window with level interrupt.
module iobus_timer
  import iobus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  timer_state_t state_q;
  logic         auto_q, ie_q, pend_q, intr_q;
  logic [31:0]  period_q, count_q;

  logic       hit, tick, expire, start, running;
  logic       wr_ctrl, wr_period, wr_status;
  logic [3:0] ofs;
  logic       unused_addr;

  assign unused_addr = ^IOBUS_ADDR[1:0];

  assign hit       = IOBUS_ADDR[31:4] == BASE_ADDR[31:4];
  assign ofs       = {IOBUS_ADDR[3:2], 2'b00};
  assign wr_ctrl   = IOBUS_WR && hit && (ofs == OFS_CTRL);
  assign wr_period = IOBUS_WR && hit && (ofs == OFS_PERIOD);
  assign wr_status = IOBUS_WR && hit && (ofs == OFS_STATUS);

  assign running = state_q == RUN;
  assign expire  = running && tick && (count_q == 32'd1);
  assign start   = wr_ctrl && IOBUS_OUT[CTRL_EN] && (period_q != 32'd0);

  iobus_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (running),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      pend_q   <= 1'b0;
      intr_q   <= 1'b0;
      period_q <= '0;
      count_q  <= '0;
    end else begin
      // Expiry set beats a simultaneous W1C clear.
      pend_q <= expire || (pend_q && !(wr_status && IOBUS_OUT[0]));
      intr_q <= pend_q && ie_q;
      if (wr_period) begin
        period_q <= IOBUS_OUT;
      end
      if (wr_ctrl) begin
        auto_q <= IOBUS_OUT[CTRL_AUTO];
        ie_q   <= IOBUS_OUT[CTRL_IE];
        if (start) begin
          state_q <= RUN;
          count_q <= period_q;
        end else begin
          state_q <= IDLE;
        end
      end else if (running && tick) begin
        if (count_q != 32'd1) begin
          count_q <= count_q - 32'd1;
        end else if (auto_q && (period_q != 32'd0)) begin
          count_q <= period_q;
        end else begin
          count_q <= '0;
          state_q <= IDLE;
        end
      end
    end
  end

  assign INTR = intr_q;

  always_comb begin
    IOBUS_IN = '0;
    if (hit) begin
      case (ofs)
        OFS_CTRL:   IOBUS_IN = {29'd0, ie_q, auto_q, running};
        OFS_PERIOD: IOBUS_IN = period_q;
        OFS_COUNT:  IOBUS_IN = count_q;
        OFS_STATUS: IOBUS_IN = {31'd0, pend_q};
        default:    IOBUS_IN = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_timer.sv
// Bench for iobus_timer: two prescale variants against a behavioural model, plus literal checks.
module tb_iobus_timer;

  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_PER  = BASE + 32'h4;
  localparam logic [31:0] A_CNT  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT  = '0;
  logic        IOBUS_WR   = 1'b0;
  logic [31:0] rd1, rd4;
  logic        intr1, intr4;
  bit          go = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iobus_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(rd1), .INTR(intr1)
  );

  iobus_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(rd4), .INTR(intr4)
  );

  // Behavioural model, index 0 = PRESCALE 1, index 1 = PRESCALE 4.
  bit          run_m[2], aut_m[2], ie_m[2], pend_m[2], intr_m[2];
  logic [31:0] per_m[2], cnt_m[2];
  int unsigned cyc_m[2];

  function automatic int unsigned ps(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {29'd0, ie_m[k], aut_m[k], run_m[k]};
      2'd1:    return per_m[k];
      2'd2:    return cnt_m[k];
      default: return {31'd0, pend_m[k]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    bit hw, tk, ex;
    logic [1:0] sel;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        run_m[k] = 0; aut_m[k] = 0; ie_m[k] = 0; pend_m[k] = 0; intr_m[k] = 0;
        per_m[k] = 0; cnt_m[k] = 0; cyc_m[k] = 0;
      end
    end else begin
      hw  = IOBUS_WR && (IOBUS_ADDR[31:4] == BASE[31:4]);
      sel = IOBUS_ADDR[3:2];
      for (int k = 0; k < 2; k++) begin
        // A tick ends every PRESCALE-th cycle spent running since the last start.
        tk = run_m[k] && ((cyc_m[k] + 1) % ps(k) == 0);
        ex = tk && (cnt_m[k] == 1);
        intr_m[k] = pend_m[k] && ie_m[k];
        pend_m[k] = ex || (pend_m[k] && !(hw && sel == 2'd3 && IOBUS_OUT[0]));
        if (run_m[k]) cyc_m[k] = cyc_m[k] + 1;
        if (hw && sel == 2'd0) begin
          aut_m[k] = IOBUS_OUT[1];
          ie_m[k]  = IOBUS_OUT[2];
          if (IOBUS_OUT[0] && per_m[k] != 0) begin
            run_m[k] = 1; cnt_m[k] = per_m[k]; cyc_m[k] = 0;
          end else begin
            run_m[k] = 0;
          end
        end else if (tk) begin
          if (cnt_m[k] > 1) cnt_m[k] = cnt_m[k] - 1;
          else if (aut_m[k] && per_m[k] != 0) cnt_m[k] = per_m[k];
          else begin cnt_m[k] = 0; run_m[k] = 0; end
        end
        if (hw && sel == 2'd1) per_m[k] = IOBUS_OUT;
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("model_rd_p1", rd1, exp_rd(0, IOBUS_ADDR));
      chk("model_intr_p1", {31'd0, intr1}, {31'd0, intr_m[0]});
      chk("model_rd_p4", rd4, exp_rd(1, IOBUS_ADDR));
      chk("model_intr_p4", {31'd0, intr4}, {31'd0, intr_m[1]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] d);
    IOBUS_WR = wr; IOBUS_ADDR = a; IOBUS_OUT = d;
    step();
    IOBUS_WR = 1'b0;
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, a, d);
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    IOBUS_ADDR = a;
    #1;
    chk(name, rd1, exp);
  endtask

  initial begin
    #1 rst = 1'b1;
    go = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Reset state
    peek("rst_ctrl", A_CTRL, 0); peek("rst_per", A_PER, 0);
    peek("rst_cnt", A_CNT, 0);   peek("rst_stat", A_STAT, 0);
    chk("rst_intr", {31'd0, intr1}, 0);
    step();

    // One-shot: PERIOD=5, EN|IE
    bus(A_PER, 5); bus(A_CTRL, 5);
    for (int i = 0; i < 5; i++) begin
      peek("oneshot_cnt", A_CNT, 32'(5 - i));
      step();
    end
    peek("oneshot_pend", A_STAT, 1);
    chk("oneshot_intr_lag", {31'd0, intr1}, 0);
    step();
    chk("oneshot_intr", {31'd0, intr1}, 1);
    peek("oneshot_ctrl", A_CTRL, 4);
    peek("oneshot_cnt0", A_CNT, 0);
    bus(A_STAT, 1);
    peek("w1c_pend", A_STAT, 0);
    step();
    chk("w1c_intr", {31'd0, intr1}, 0);

    // Auto-reload: PERIOD=3, EN|AUTO|IE
    bus(A_PER, 3); bus(A_CTRL, 7);
    for (int i = 0; i < 6; i++) begin
      peek("auto_cnt", A_CNT, 32'(3 - (i % 3)));
      step();
    end
    peek("auto_reload", A_CNT, 3);
    step();
    bus(A_PER, 10);
    peek("auto_per_mid", A_CNT, 1);
    step();
    peek("auto_new_per", A_CNT, 10);
    bus(A_CTRL, 0); bus(A_STAT, 1);

    // Collision: W1C on the expiry cycle
    bus(A_PER, 2); bus(A_CTRL, 5); step();
    bus(A_STAT, 1);
    peek("coll_w1c_pend", A_STAT, 1);
    peek("coll_w1c_cnt", A_CNT, 0);
    bus(A_STAT, 1);
    peek("coll_clr", A_STAT, 0);

    // Collision: EN=0 on the expiry cycle
    bus(A_CTRL, 5); step();
    bus(A_CTRL, 4);
    peek("coll_ctrl", A_CTRL, 4);
    peek("coll_ctrl_cnt", A_CNT, 1);
    peek("coll_ctrl_pend", A_STAT, 1);
    bus(A_STAT, 1);

    // Decode
    peek("dec_above", BASE + 32'h10, 0);
    peek("dec_below", BASE - 32'h4, 0);
    bus(BASE + 32'h14, 99);
    peek("dec_wr_out", A_PER, 2);
    bus(A_CNT, 77);
    peek("dec_wr_cnt", A_CNT, 1);
    peek("dec_byte_ofs", A_PER + 32'h3, 2);

    // Edge values
    bus(A_PER, 0); bus(A_CTRL, 1);
    peek("per0_ctrl", A_CTRL, 0);
    bus(A_PER, 32'hFFFF_FFFF); bus(A_CTRL, 1);
    peek("max_load", A_CNT, 32'hFFFF_FFFF);
    step();
    peek("max_dec", A_CNT, 32'hFFFF_FFFE);
    bus(A_CTRL, 0);

    // Prescale 4, PERIOD=2: expiry at edge 8
    bus(A_STAT, 1); bus(A_PER, 2); bus(A_CTRL, 1);
    repeat (7) step();
    IOBUS_ADDR = A_STAT; #1;
    chk("psc4_before", rd4, 0);
    step();
    chk("psc4_expire", rd4, 1);

    // Reset mid-count with INTR high
    bus(A_CTRL, 0); bus(A_STAT, 1);
    bus(A_PER, 1); bus(A_CTRL, 5); step(); step();
    bus(A_PER, 10); bus(A_CTRL, 5);
    repeat (3) step();
    peek("mid_cnt", A_CNT, 7);
    chk("mid_intr", {31'd0, intr1}, 1);
    #1 rst = 1'b1;
    #1 chk("arst_intr", {31'd0, intr1}, 0);
    peek("arst_cnt", A_CNT, 0);
    peek("arst_per", A_PER, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    peek("post_rst_cnt", A_CNT, 0);
    peek("post_rst_ctrl", A_CTRL, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] a, d;
      int unsigned r;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        step();
        #2 rst = 1'b0;
        step();
      end else begin
        r = $urandom_range(0, 11);
        if (r == 10) a = BASE + 32'h10;
        else if (r == 11) a = BASE - 32'h4;
        else a = BASE + 32'(($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
        if (a[3:2] == 2'd1 && a[31:4] == BASE[31:4])
          d = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
        else
          d = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
        drive($urandom_range(0, 3) == 0, a, d);
      end
    end

    go = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
